sram_io_burst_ctrl: RTL and testbench

- Avalon-MM slave that streams bursts of {address, data} frames between the FPGA and the on-chip SCPU IO controller over the serial load/si/so link.
- Parametrised successor of the single-frame SRAM IO control logic.
- Adds a TX FIFO, an RX FIFO, auto-incrementing addresses, multi-frame bursts, a programmable bit period, abort, and sticky error/done status.
- Sits between the Nios/Avalon fabric and the chip I/O pins.

---
 rtl/sram_io_burst_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_sram_io_burst_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_io_burst_ctrl.sv
// Avalon-MM burst controller for the SCPU IO serial link (load/si/so).
// TX/RX FIFOs, auto-incrementing frame address, programmable bit period, abort, sticky status.
module sram_io_burst_ctrl #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int FRAME_BITS        = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH,
    parameter int FIFO_DEPTH        = 16,
    parameter int BIT_DIV           = 1
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [31:0] avs_cpuctrl_writedata,
    input  logic        avs_cpuctrl_write,
    output logic [31:0] avs_cpustat_readdata,
    input  logic [31:0] avs_sram_addr_writedata,
    input  logic        avs_sram_addr_write,
    input  logic [31:0] avs_sram_data_writedata,
    input  logic        avs_sram_data_write,
    input  logic        avs_sram_data_read,
    output logic [31:0] avs_sram_data_readdata,
    output logic        coe_ctrl_load_export,
    output logic        coe_ctrl_si_export,
    output logic        coe_ctrl_mod0_export,
    output logic        coe_ctrl_mod1_export,
    input  logic        coe_ctrl_so_export,
    input  logic        coe_ctrl_rdy_export
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t                       state;
    logic [1:0]                   mode;
    logic [7:0]                   frames_rem;
    logic [MEMORY_ADDR_WIDTH-1:0] base_addr;
    logic [MEMORY_ADDR_WIDTH-1:0] addr_cnt;
    logic [DW-1:0]                div_cnt;
    logic [BW-1:0]                bit_idx;
    logic [FRAME_BITS-1:0]        tx_sh;
    logic [FRAME_BITS-1:0]        rx_sh;
    logic                         stall;
    logic                         done;
    logic                         tx_ovf;
    logic                         rx_ovf;

    logic [MEMORY_DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]                tx_wp, tx_rp;
    logic [PW:0]                  tx_cnt;
    logic [FRAME_BITS-1:0]        rx_mem [FIFO_DEPTH];
    logic [PW-1:0]                rx_wp, rx_rp;
    logic [PW:0]                  rx_cnt;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_pop, tx_push_ok, rx_push, rx_push_ok, rx_pop;
    logic ctl_start, ctl_abort, start_ok, period_end, last_bit, frame_next;
    logic [FRAME_BITS-1:0] rx_word;
    logic unused_bits;

    // Avalon strobes are zero-wait-state: every write/read strobe is consumed in the cycle it is high.
    assign ctl_abort  = avs_cpuctrl_write & avs_cpuctrl_writedata[1];
    assign ctl_start  = avs_cpuctrl_write & avs_cpuctrl_writedata[0] & ~avs_cpuctrl_writedata[1];
    assign start_ok   = ctl_start && (state == S_IDLE) && (avs_cpuctrl_writedata[15:8] != 8'd0);
    assign period_end = (div_cnt == DIV_LAST);
    assign last_bit   = (state == S_SHIFT) && period_end && (bit_idx == BIT_LAST);
    assign frame_next = (state == S_GAP) && period_end && (stall || frames_rem != 8'd1);
    assign rx_word    = {coe_ctrl_so_export, rx_sh[FRAME_BITS-1:1]};

    assign tx_full  = (tx_cnt == DEPTH_C);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == DEPTH_C);
    assign rx_empty = (rx_cnt == '0);

    always_comb begin
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        if (!ctl_abort) begin
            if (start_ok)
                tx_pop = (avs_cpuctrl_writedata[3:2] == 2'b00) && !tx_empty;
            else if (frame_next && mode == 2'b00)
                tx_pop = !tx_empty;
            rx_push = last_bit && (mode == 2'b10);
        end
    end

    assign rx_pop     = avs_sram_data_read && !rx_empty;
    assign tx_push_ok = avs_sram_data_write && (!tx_full || tx_pop);
    assign rx_push_ok = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge csi_clk) begin
        if (tx_push_ok) tx_mem[tx_wp] <= avs_sram_data_writedata[MEMORY_DATA_WIDTH-1:0];
        if (rx_push_ok) rx_mem[rx_wp] <= rx_word;
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            tx_ovf <= 1'b0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_push_ok) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)     tx_rp <= tx_rp + 1'b1;
            if (tx_push_ok && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push_ok && tx_pop) tx_cnt <= tx_cnt - 1'b1;
            if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)     rx_rp <= rx_rp + 1'b1;
            if (rx_push_ok && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push_ok && rx_pop) rx_cnt <= rx_cnt - 1'b1;
            // A new overflow in the same cycle as the start that clears it still sticks.
            if (start_ok) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (avs_sram_data_write && !tx_push_ok) tx_ovf <= 1'b1;
            if (rx_push && !rx_push_ok)             rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset)                base_addr <= '0;
        else if (avs_sram_addr_write) base_addr <= avs_sram_addr_writedata[MEMORY_ADDR_WIDTH-1:0];
    end

    always_ff @(posedge csi_clk or posedge rsi_reset) begin
        if (rsi_reset) begin
            state                <= S_IDLE;
            mode                 <= 2'b00;
            frames_rem           <= '0;
            addr_cnt             <= '0;
            div_cnt              <= '0;
            bit_idx              <= '0;
            tx_sh                <= '0;
            rx_sh                <= '0;
            stall                <= 1'b0;
            done                 <= 1'b0;
            coe_ctrl_load_export <= 1'b0;
            coe_ctrl_si_export   <= 1'b0;
            coe_ctrl_mod0_export <= 1'b0;
            coe_ctrl_mod1_export <= 1'b0;
        end else if (ctl_abort) begin
            state                <= S_IDLE;
            div_cnt              <= '0;
            stall                <= 1'b0;
            coe_ctrl_load_export <= 1'b0;
            coe_ctrl_si_export   <= 1'b0;
            coe_ctrl_mod0_export <= 1'b0;
            coe_ctrl_mod1_export <= 1'b0;
        end else begin
            if (state != S_IDLE) div_cnt <= period_end ? '0 : div_cnt + 1'b1;
            case (state)
                S_IDLE: if (start_ok) begin
                    mode                 <= avs_cpuctrl_writedata[3:2];
                    addr_cnt             <= base_addr;
                    div_cnt              <= '0;
                    done                 <= 1'b0;
                    coe_ctrl_mod0_export <= avs_cpuctrl_writedata[2];
                    coe_ctrl_mod1_export <= avs_cpuctrl_writedata[3] & avs_cpuctrl_writedata[2];
                    frames_rem           <= avs_cpuctrl_writedata[2] ? 8'd0 : avs_cpuctrl_writedata[15:8];
                    if (avs_cpuctrl_writedata[3:2] == 2'b00 && tx_empty) begin
                        state <= S_GAP;
                        stall <= 1'b1;
                    end else begin
                        state                <= S_LOAD;
                        coe_ctrl_load_export <= 1'b1;
                        tx_sh                <= {base_addr, tx_mem[tx_rp]};
                    end
                end
                S_LOAD: if (period_end) begin
                    coe_ctrl_load_export <= 1'b0;
                    if (mode[0]) begin
                        state                <= S_IDLE;
                        done                 <= 1'b1;
                        coe_ctrl_mod0_export <= 1'b0;
                        coe_ctrl_mod1_export <= 1'b0;
                    end else begin
                        state              <= S_SHIFT;
                        bit_idx            <= '0;
                        coe_ctrl_si_export <= (mode == 2'b00) & tx_sh[0];
                        tx_sh              <= tx_sh >> 1;
                    end
                end
                S_SHIFT: if (period_end) begin
                    rx_sh <= rx_word;
                    if (bit_idx == BIT_LAST) begin
                        state              <= S_GAP;
                        coe_ctrl_si_export <= 1'b0;
                        addr_cnt           <= addr_cnt + 1'b1;
                    end else begin
                        bit_idx            <= bit_idx + 1'b1;
                        coe_ctrl_si_export <= (mode == 2'b00) & tx_sh[0];
                        tx_sh              <= tx_sh >> 1;
                    end
                end
                S_GAP: if (period_end) begin
                    // A stalled GAP is an underrun wait, not a frame's trailing gap: no decrement.
                    if (!stall && frames_rem == 8'd1) begin
                        state                <= S_IDLE;
                        frames_rem           <= 8'd0;
                        done                 <= 1'b1;
                        coe_ctrl_mod0_export <= 1'b0;
                        coe_ctrl_mod1_export <= 1'b0;
                    end else begin
                        if (!stall) frames_rem <= frames_rem - 8'd1;
                        if (mode == 2'b00 && tx_empty) begin
                            stall <= 1'b1;
                        end else begin
                            stall                <= 1'b0;
                            state                <= S_LOAD;
                            coe_ctrl_load_export <= 1'b1;
                            tx_sh                <= {addr_cnt, tx_mem[tx_rp]};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign avs_cpustat_readdata = {16'd0, frames_rem, done, rx_ovf, tx_ovf, rx_empty, tx_empty,
                                   tx_full, (state != S_IDLE), coe_ctrl_rdy_export};
    assign avs_sram_data_readdata = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp]);

    assign unused_bits = ^{avs_cpuctrl_writedata[31:16], avs_cpuctrl_writedata[7:4],
                           avs_sram_addr_writedata[31:MEMORY_ADDR_WIDTH],
                           avs_sram_data_writedata[31:MEMORY_DATA_WIDTH], rx_sh[0]};

endmodule

// File: tb/tb_sram_io_burst_ctrl.sv
// Directed bench for sram_io_burst_ctrl: table of single-frame bursts plus
// hand-written sequences for multi-frame, stall, overflow, abort and reset cases.
module tb_sram_io_burst_ctrl;

    localparam int FB = 17;

    logic        csi_clk = 1'b0;
    logic        rsi_reset;
    logic [31:0] ctrl_wd;
    logic        ctrl_we;
    logic [31:0] stat;
    logic [31:0] addr_wd;
    logic        addr_we;
    logic [31:0] data_wd;
    logic        data_we;
    logic        data_re;
    logic [31:0] rd_data;
    logic        load, si, mod0, mod1, so, rdy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    sram_io_burst_ctrl dut (
        .csi_clk                 (csi_clk),
        .rsi_reset               (rsi_reset),
        .avs_cpuctrl_writedata   (ctrl_wd),
        .avs_cpuctrl_write       (ctrl_we),
        .avs_cpustat_readdata    (stat),
        .avs_sram_addr_writedata (addr_wd),
        .avs_sram_addr_write     (addr_we),
        .avs_sram_data_writedata (data_wd),
        .avs_sram_data_write     (data_we),
        .avs_sram_data_read      (data_re),
        .avs_sram_data_readdata  (rd_data),
        .coe_ctrl_load_export    (load),
        .coe_ctrl_si_export      (si),
        .coe_ctrl_mod0_export    (mod0),
        .coe_ctrl_mod1_export    (mod1),
        .coe_ctrl_so_export      (so),
        .coe_ctrl_rdy_export     (rdy)
    );

    // clock / watchdog
    always #5 csi_clk = ~csi_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_word(input logic [1:0] mode, input logic [7:0] cnt,
                                              input logic start, input logic abort);
        return {16'd0, cnt, 4'd0, mode, abort, start};
    endfunction

    // driver tasks: each returns on the falling edge after the strobe was sampled
    task automatic ctrl_write(input logic [31:0] wd);
        @(negedge csi_clk);
        ctrl_wd = wd;
        ctrl_we = 1'b1;
        @(negedge csi_clk);
        ctrl_we = 1'b0;
    endtask

    task automatic set_base(input logic [31:0] a);
        @(negedge csi_clk);
        addr_wd = a;
        addr_we = 1'b1;
        @(negedge csi_clk);
        addr_we = 1'b0;
    endtask

    task automatic push_tx(input logic [31:0] d);
        @(negedge csi_clk);
        data_wd = d;
        data_we = 1'b1;
        @(negedge csi_clk);
        data_we = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge csi_clk);
        data_re = 1'b1;
        @(negedge csi_clk);
        data_re = 1'b0;
    endtask

    task automatic capture_frame(output logic [FB-1:0] f);
        int waits = 0;
        f = '0;
        while (load !== 1'b1 && waits < 200) begin
            @(negedge csi_clk);
            waits++;
        end
        chk("load_seen", {31'd0, load}, 32'd1);
        for (int k = 0; k < FB; k++) begin
            @(negedge csi_clk);
            f[k] = si;
            if (k == 0) chk("load_pulse", {31'd0, load}, 32'd0);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (stat[1] !== 1'b0 && n < max_cycles) begin
            @(negedge csi_clk);
            n++;
        end
        chk("idle_timeout", {31'd0, stat[1]}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [8:0]  base;
        logic [7:0]  data;
        logic [16:0] so_word;
        logic [31:0] exp_word;
        logic [31:0] exp_stat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [FB-1:0] f;
        logic [FB-1:0] w;
        int            loads;
        int            k;
        int            n;
        logic          prev;

        vecs[0] = '{2'b00, 9'h1FE, 8'hA5, 17'h0,     32'h0001FEA5, 32'h00000098};
        vecs[1] = '{2'b00, 9'h000, 8'h00, 17'h0,     32'h00000000, 32'h00000098};
        vecs[2] = '{2'b00, 9'h1FF, 8'hFF, 17'h0,     32'h0001FFFF, 32'h00000098};
        vecs[3] = '{2'b00, 9'h155, 8'h5A, 17'h0,     32'h0001555A, 32'h00000098};
        vecs[4] = '{2'b10, 9'h000, 8'h00, 17'h1A5B5, 32'h0001A5B5, 32'h00000088};
        vecs[5] = '{2'b10, 9'h000, 8'h00, 17'h00001, 32'h00000001, 32'h00000088};
        vecs[6] = '{2'b10, 9'h000, 8'h00, 17'h10000, 32'h00010000, 32'h00000088};

        // reset
        rsi_reset = 1'b1;
        ctrl_wd = '0; ctrl_we = 1'b0;
        addr_wd = '0; addr_we = 1'b0;
        data_wd = '0; data_we = 1'b0; data_re = 1'b0;
        so = 1'b0; rdy = 1'b0;
        repeat (2) @(negedge csi_clk);
        chk("reset_stat", stat, 32'h00000018);
        chk("reset_pins", {28'd0, load, si, mod1, mod0}, 32'd0);
        chk("reset_rd", rd_data, 32'd0);
        rdy = 1'b1;
        #1;
        chk("rdy_stat", stat, 32'h00000019);
        rdy = 1'b0;
        @(negedge csi_clk);
        rsi_reset = 1'b0;

        // table: single-frame writes and reads
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].mode == 2'b00) begin
                set_base({23'd0, vecs[i].base});
                push_tx({24'd0, vecs[i].data});
                exp_q.push_back(vecs[i].exp_word);
                ctrl_write(ctrl_word(2'b00, 8'd1, 1'b1, 1'b0));
                chk("vec_mod_wr", {30'd0, mod1, mod0}, 32'd0);
                capture_frame(f);
                chk("vec_frame", {15'd0, f}, exp_q.pop_front());
                wait_idle(50);
                chk("vec_stat", stat, vecs[i].exp_stat);
            end else begin
                w = vecs[i].so_word;
                ctrl_write(ctrl_word(2'b10, 8'd1, 1'b1, 1'b0));
                chk("vec_mod_rd", {29'd0, load, mod1, mod0}, 32'h4);
                for (int b = 0; b < FB; b++) begin
                    @(negedge csi_clk);
                    so = w[b];
                    if (b == 3) chk("vec_rd_si", {31'd0, si}, 32'd0);
                end
                wait_idle(50);
                chk("vec_rx_head", rd_data, vecs[i].exp_word);
                chk("vec_stat", stat, vecs[i].exp_stat);
                pop_rx();
                chk("vec_rx_empty", {31'd0, stat[4]}, 32'd1);
                so = 1'b0;
            end
        end

        // two-frame burst with address increment and exact completion cycle
        set_base(32'h1FE);
        push_tx(32'hA5);
        push_tx(32'h3C);
        exp_q.push_back(32'h0001FEA5);
        exp_q.push_back(32'h0001FF3C);
        ctrl_write(ctrl_word(2'b00, 8'd2, 1'b1, 1'b0));
        capture_frame(f);
        chk("burst_f1", {15'd0, f}, exp_q.pop_front());
        @(negedge csi_clk);
        chk("burst_gap", {22'd0, stat[15:8], load, si}, {22'd0, 8'd2, 2'b00});
        capture_frame(f);
        chk("burst_f2", {15'd0, f}, exp_q.pop_front());
        @(negedge csi_clk);
        chk("burst_c37", stat & 32'h82, 32'h02);
        @(negedge csi_clk);
        chk("burst_c38", stat, 32'h00000098);

        // TX underrun stall, then resume
        set_base(32'h010);
        push_tx(32'h11);
        ctrl_write(ctrl_word(2'b00, 8'd3, 1'b1, 1'b0));
        repeat (30) @(negedge csi_clk);
        chk("stall_stat", stat, 32'h0000021A);
        chk("stall_pins", {30'd0, load, si}, 32'd0);
        push_tx(32'h22);
        push_tx(32'h33);
        wait_idle(200);
        chk("stall_done", stat, 32'h00000098);

        // TX overflow and 16-frame burst with address wrap
        set_base(32'h1F8);
        for (int i = 0; i < 17; i++) push_tx(32'h40 + i);
        chk("txovf_stat", stat, 32'h000000B4);
        ctrl_write(ctrl_word(2'b00, 8'd16, 1'b1, 1'b0));
        loads = 0; k = FB; n = 0; prev = 1'b0; f = '0;
        while (stat[1] === 1'b1 && n < 1000) begin
            if (k < FB) begin
                if (loads == 16) f[k] = si;
                k++;
            end
            if (load === 1'b1 && prev === 1'b0) begin
                loads++;
                k = 0;
            end
            prev = load;
            @(negedge csi_clk);
            n++;
        end
        chk("burst16_loads", loads, 32'd16);
        chk("burst16_last", {15'd0, f}, 32'h0000074F);
        chk("burst16_stat", stat, 32'h00000098);

        // abort mid-SHIFT
        push_tx(32'hA5);
        ctrl_write(ctrl_word(2'b00, 8'd1, 1'b1, 1'b0));
        repeat (6) @(negedge csi_clk);
        chk("abort_pre_si", {31'd0, si}, 32'd1);
        ctrl_write(ctrl_word(2'b00, 8'd0, 1'b0, 1'b1));
        chk("abort_stat", stat & 32'hFF, 32'h18);
        chk("abort_pins", {28'd0, load, si, mod1, mod0}, 32'd0);

        // RX overflow: fill RX, then a read burst into a full FIFO
        so = 1'b1;
        ctrl_write(ctrl_word(2'b10, 8'd16, 1'b1, 1'b0));
        wait_idle(600);
        chk("rxfill_stat", stat, 32'h00000088);
        so = 1'b0;
        ctrl_write(ctrl_word(2'b10, 8'd2, 1'b1, 1'b0));
        wait_idle(100);
        chk("rxovf_stat", stat, 32'h000000C8);
        for (int i = 0; i < 16; i++) begin
            chk("rxovf_head", rd_data, 32'h0001FFFF);
            pop_rx();
        end
        chk("rxovf_empty", {31'd0, stat[4]}, 32'd1);
        pop_rx();
        chk("rx_pop_empty", rd_data, 32'd0);

        // on-chip transfer modes
        ctrl_write(ctrl_word(2'b11, 8'd1, 1'b1, 1'b0));
        chk("xfer11_pins", {29'd0, load, mod1, mod0}, 32'h7);
        @(negedge csi_clk);
        chk("xfer11_end", {28'd0, stat[7:4] & 4'h8, load, mod1, mod0, stat[1]}, 32'h80);

        // asynchronous reset mid-burst
        push_tx(32'h77);
        ctrl_write(ctrl_word(2'b01, 8'd1, 1'b1, 1'b0));
        chk("xfer01_pins", {29'd0, load, mod1, mod0}, 32'h5);
        #2;
        rsi_reset = 1'b1;
        #1;
        chk("midrst_pins", {28'd0, load, si, mod1, mod0}, 32'd0);
        chk("midrst_stat", stat, 32'h00000018);
        @(negedge csi_clk);
        rsi_reset = 1'b0;
        @(negedge csi_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
